// File: rtl/nn_pkg.sv
// Shared output-layer definitions: classifier dimensions and scheduler states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 16;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/argmax_acc.sv
// Running maximum register: tracks the largest score seen so far and its index.
// Latency: one cycle from a load strobe to updated max_score/max_idx.
// Backpressure: none; the caller strobes load only when a score is accepted.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   load               a score is presented this cycle
//   first              this score starts a new scan (overwrite unconditionally)
//   in_idx, in_score   index and unsigned score being offered
//   max_idx, max_score current winner
module argmax_acc #(
  parameter int SCORE_W = nn_pkg::SCORE_W,
  parameter int IDX_W   = nn_pkg::IDX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               first,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic [SCORE_W-1:0] in_score,
  output logic [IDX_W-1:0]   max_idx,
  output logic [SCORE_W-1:0] max_score
);

  logic take;

  // Strict greater-than keeps the earliest index on ties.
  assign take = load && (first || (in_score > max_score));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_idx   <= '0;
      max_score <= '0;
    end else if (take) begin
      max_idx   <= in_idx;
      max_score <= in_score;
    end
  end

endmodule

// File: rtl/argmax_sched.sv
// Sequenced argmax over the output layer: one MAC request per neuron, then report winner.
// Latency: 2*NUM_CLASSES+1 cycles from start to result_valid with zero-wait MAC engine.
// Backpressure: req_ready stalls hold the request stable; result held until result_ready.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   start, abort                    controller commands (start sampled in IDLE only)
//   busy                            high in any state except IDLE
//   req_valid, req_ready, req_idx   neuron evaluation request to the MAC engine
//   score_valid, score_data         one-cycle score return for the outstanding request
//   result_valid, result_ready      winner handshake
//   result_idx, result_score        winning class and its score
//   proto_err                       sticky: score seen outside WAIT
module argmax_sched
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
  parameter int SCORE_W     = nn_pkg::SCORE_W,
  parameter int IDX_W       = nn_pkg::IDX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [IDX_W-1:0]   req_idx,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score_data,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [IDX_W-1:0]   result_idx,
  output logic [SCORE_W-1:0] result_score,
  output logic               proto_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               proto_err_nxt;
  logic               acc_load;
  logic [IDX_W-1:0]   max_idx;
  logic [SCORE_W-1:0] max_score;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      proto_err <= proto_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    acc_load      = 1'b0;
    proto_err_nxt = proto_err;

    case (state)
      IDLE: begin
        // abort outranks everything, including a start arriving alongside it.
        if (start && !abort) begin
          state_nxt     = ISSUE;
          idx_nxt       = '0;
          proto_err_nxt = 1'b0;
        end
      end
      ISSUE: begin
        if (abort)          state_nxt = IDLE;
        else if (req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (score_valid) begin
          acc_load = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = ISSUE;
          end
        end
      end
      DONE: begin
        if (abort || result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A score outside WAIT has no request to belong to. Evaluated after the
    // start clear so a stray score in the start cycle is still flagged.
    if (score_valid && (state != WAIT)) proto_err_nxt = 1'b1;
  end

  argmax_acc #(
    .SCORE_W (SCORE_W),
    .IDX_W   (IDX_W)
  ) u_acc (
    .clk       (clk),
    .reset     (reset),
    .load      (acc_load),
    .first     (idx == '0),
    .in_idx    (idx),
    .in_score  (score_data),
    .max_idx   (max_idx),
    .max_score (max_score)
  );

  // Outputs decode from state so an abort or reset drops them at once;
  // data buses are gated to zero whenever their valid is low.
  assign busy         = (state != IDLE);
  assign req_valid    = (state == ISSUE);
  assign req_idx      = req_valid ? idx : '0;
  assign result_valid = (state == DONE);
  assign result_idx   = result_valid ? max_idx : '0;
  assign result_score = result_valid ? max_score : '0;

endmodule

// File: tb/tb_argmax_sched.sv
module tb_argmax_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [3:0]  req_idx;
  logic        score_valid = 1'b0;
  logic [15:0] score_data = '0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [3:0]  result_idx;
  logic [15:0] result_score;
  logic        proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sc [10];

  always #5 clk = ~clk;

  argmax_sched dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_idx      (req_idx),
    .score_valid  (score_valid),
    .score_data   (score_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_idx   (result_idx),
    .result_score (result_score),
    .proto_err    (proto_err)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives one classification with a cycle-accurate responder. All I/O at negedge.
  // abort_idx >= 0 aborts in the WAIT of that neuron and probes the stray-score path.
  task automatic run_scan(input int req_stall, input int res_stall, input bit extra_start,
                          input int abort_idx, input int exp_idx, input int exp_score,
                          input int exp_rise);
    int cyc = 0;
    int stall = 0;
    int res_wait = 0;
    int pidx = 0;
    int next_idx = 0;
    bit pend = 0;
    bit seen_res = 0;
    bit done = 0;

    @(negedge clk);
    start = 1; req_ready = 0; result_ready = 0; score_valid = 0;
    @(negedge clk);
    start = 0;
    cyc = 1;
    check_val("start_clears_perr", int'(proto_err), 0);
    check_val("busy_after_start", int'(busy), 1);

    while (!done && cyc < 400) begin
      score_valid = 0; req_ready = 0; result_ready = 0; start = 0;
      if (pend) begin
        pend = 0;
        if (pidx == abort_idx) begin
          check_val("abort_in_wait_busy", int'(busy), 1);
          check_val("abort_in_wait_reqv", int'(req_valid), 0);
          abort = 1;
          @(negedge clk);
          abort = 0;
          check_val("abort_busy", int'(busy), 0);
          check_val("abort_reqv", int'(req_valid), 0);
          check_val("abort_resv", int'(result_valid), 0);
          check_val("abort_perr_pre", int'(proto_err), 0);
          score_valid = 1; score_data = 16'h1234;
          @(negedge clk);
          score_valid = 0;
          check_val("stray_perr", int'(proto_err), 1);
          check_val("stray_busy", int'(busy), 0);
          return;
        end
        score_valid = 1;
        score_data  = sc[pidx];
      end
      if (req_valid) begin
        check_val("req_idx", int'(req_idx), next_idx);
        if (stall < req_stall) begin
          stall++;
        end else begin
          req_ready = 1;
          pend      = 1;
          pidx      = next_idx;
          next_idx++;
          stall     = 0;
        end
      end
      if (result_valid) begin
        if (!seen_res) begin
          seen_res = 1;
          check_val("result_rise_cycle", cyc, exp_rise);
        end
        check_val("result_idx", int'(result_idx), exp_idx);
        check_val("result_score", int'(result_score), exp_score);
        if (extra_start) start = 1;
        if (res_wait < res_stall) begin
          res_wait++;
        end else begin
          result_ready = 1;
          done = 1;
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end

    if (!done) check_val("scan_timeout", 0, 1);

    @(negedge clk);
    start = 0; result_ready = 0; score_valid = 0; req_ready = 0;
    check_val("idle_after_accept", int'(busy), 0);
    check_val("resv_after_accept", int'(result_valid), 0);
    @(negedge clk);
    check_val("start_in_done_ignored", int'(busy), 0);
  endtask

  initial begin
    // Reset state
    #2;
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_reqv", int'(req_valid), 0);
    check_val("rst_req_idx", int'(req_idx), 0);
    check_val("rst_resv", int'(result_valid), 0);
    check_val("rst_res_idx", int'(result_idx), 0);
    check_val("rst_res_score", int'(result_score), 0);
    check_val("rst_perr", int'(proto_err), 0);
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check_val("post_rst_busy", int'(busy), 0);

    // Basic scan, zero-wait; start also held with result_ready in DONE
    sc = '{16'd5, 16'd9, 16'd3, 16'd12, 16'd7, 16'd1, 16'd0, 16'd11, 16'd2, 16'd4};
    run_scan(0, 0, 1'b1, -1, 3, 12, 21);

    // All equal: lowest index wins
    sc = '{16'd100, 16'd100, 16'd100, 16'd100, 16'd100,
           16'd100, 16'd100, 16'd100, 16'd100, 16'd100};
    run_scan(0, 0, 1'b0, -1, 0, 100, 21);

    // Ties among leaders
    sc = '{16'd50, 16'd50, 16'd60, 16'd60, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    run_scan(0, 0, 1'b0, -1, 2, 60, 21);

    // Backpressure: 3 stall cycles per request, 5 on result, start during DONE
    sc = '{16'd5, 16'd9, 16'd3, 16'd12, 16'd7, 16'd1, 16'd0, 16'd11, 16'd2, 16'd4};
    run_scan(3, 5, 1'b1, -1, 3, 12, 51);

    // Abort in WAIT of neuron 4, stray score afterwards, then a clean scan
    run_scan(0, 0, 1'b0, 4, 0, 0, 0);
    sc = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6, 16'd5, 16'd3};
    run_scan(0, 0, 1'b0, -1, 5, 9, 21);

    // Asynchronous reset in the middle of ISSUE for neuron 1
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0; req_ready = 1;
    @(negedge clk);
    req_ready = 0; score_valid = 1; score_data = 16'd7;
    @(negedge clk);
    score_valid = 0;
    check_val("mid_issue_reqv", int'(req_valid), 1);
    check_val("mid_issue_req_idx", int'(req_idx), 1);
    score_valid = 1; score_data = 16'd8;
    @(negedge clk);
    score_valid = 0;
    check_val("stray_in_issue_perr", int'(proto_err), 1);
    check_val("stray_in_issue_reqv", int'(req_valid), 1);
    #2 reset = 1;
    #1;
    check_val("arst_busy", int'(busy), 0);
    check_val("arst_reqv", int'(req_valid), 0);
    check_val("arst_req_idx", int'(req_idx), 0);
    check_val("arst_perr", int'(proto_err), 0);
    check_val("arst_resv", int'(result_valid), 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check_val("arst_release_busy", int'(busy), 0);
    sc = '{16'd10, 16'd20, 16'd300, 16'hFFFE, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'hFFFF};
    run_scan(0, 0, 1'b0, -1, 9, 65535, 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/argmax_sched.md
Name: argmax_sched

Overview:
- Sequencer for the output-layer classification step.
- Issues one output-neuron evaluation request at a time to the shared output-layer MAC engine and collects each returned score over a valid handshake.
- Keeps a running maximum and reports the winning class index and its score through a result valid/ready handshake.
- Sits between the top-level inference controller (start/abort) and the output-layer datapath, replacing the 10-wide parallel compare with a sequenced scan.

Parameters:
- NUM_CLASSES, 10, number of output neurons scanned per classification (must be ≥2).
- SCORE_W, 16, unsigned score width.
- IDX_W, 4, class index width (must hold NUM_CLASSES-1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a classification; sampled in IDLE only.
- abort  in  1  synchronous abort; returns to IDLE next edge.
- busy  out  1  high in any state except IDLE.
- req_valid  out  1  request to evaluate neuron req_idx.
- req_ready  in  1  MAC engine accepts request.
- req_idx  out  IDX_W  neuron index requested.
- score_valid  in  1  one-cycle score return for the outstanding request.
- score_data  in  SCORE_W  unsigned score.
- result_valid  out  1  result available; held until accepted.
- result_ready  in  1  consumer accepts result.
- result_idx  out  IDX_W  winning class index.
- result_score  out  SCORE_W  winning score.
- proto_err  out  1  sticky protocol error flag; cleared only by reset or start.

Behaviour:
- Reset values: state IDLE; all outputs 0; internal index, max and max_idx 0.
- States:
  - IDLE: busy=0. start=1 → ISSUE with idx=0 and proto_err cleared.
  - ISSUE: req_valid=1, req_idx=idx. req_valid and req_idx stay stable until req_ready. On handshake → WAIT.
  - WAIT: req_valid=0. On score_valid:
    - idx==0: max←score_data, max_idx←0 unconditionally.
    - otherwise: update max and max_idx only if score_data > max (strict, unsigned), so ties keep the lowest index.
    - Then, if idx==NUM_CLASSES-1 → DONE; else idx+1 → ISSUE.
  - DONE: result_valid=1, result_idx=max_idx, result_score=max. Both are stable while result_valid. On result_ready → IDLE.
- Only one request is outstanding at a time; there is no pipelining across neurons.
- Latency with req_ready tied high and the score returned the cycle after the handshake:
  - start sampled in cycle 0.
  - Neuron k handshake in cycle 1+2k; its score in cycle 2+2k.
  - result_valid rises in cycle 2·NUM_CLASSES+1 (cycle 21 for the default).
  - Stalls on req_ready or late scores add cycles 1:1.
- start while busy: ignored, no effect.
- start in the same cycle as result_ready in DONE: ignored. A new start is needed in IDLE.
- abort: from any non-IDLE state, go to IDLE at the next edge. Outputs drop to 0 and req_valid deasserts even without a handshake. A score arriving later is treated as a stray score (see below). abort has priority over every other event in the same cycle.
- Stray score_valid in IDLE, ISSUE or DONE: the score is ignored and proto_err is set.
- Asynchronous reset mid-operation: immediate return to IDLE with reset values. No partial result is emitted.
- The idx counter never wraps; it saturates at NUM_CLASSES-1 by construction.

Decomposition:
- Shared package nn_pkg holds:
  - state enum typedef {IDLE, ISSUE, WAIT, DONE}.
  - localparams NUM_CLASSES, SCORE_W, IDX_W, reused by the output layer and top level.
- One sub-module is natural: argmax_acc, the running max/max_idx register with the init/compare/update logic, reusable for hidden-layer diagnostics.
- The FSM and counter stay in argmax_sched.

Test Plan:
- Basic scan: scores 5,9,3,12,7,1,0,11,2,4, zero-wait responder → result_idx=3, result_score=12, result_valid in cycle 21 after start.
- Ties and first-element maximum:
  - scores all 100 → result_idx=0.
  - scores 50,50,60,60,… (rest 0) → result_idx=2, result_score=60.
- Backpressure: req_ready low for 3 cycles on each request, result_ready low for 5 cycles → result held stable, correct index, result_valid rises 30 cycles later than the zero-wait case; a second start during DONE is ignored.
- Abort during WAIT of neuron 4 → IDLE next edge, busy=0, req_valid=0. A score then returned sets proto_err=1. The next start clears proto_err and completes normally.
- Asynchronous reset asserted mid-ISSUE (not on a clock edge) → all outputs 0 immediately. After release, a full scan with scores in which 0xFFFF is the maximum at index 9 → result_idx=9, result_score=0xFFFF.
